// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle command sequencer for the arithmetic datapath.
//                Accepts one operation at a time over a valid/ready request
//                handshake and holds the result on a valid/ready response
//                handshake until it is consumed.
//                  add/sub : one EXEC cycle, two's-complement, overflow flag
//                  mult    : WIDTH-step MSB-first shift-add, unsigned
//                  div/mod : WIDTH-step restoring division, unsigned
//                  B=0 div/mod and reserved commands: result 0, error 1
//  Ports       : clk, rst_n (async active-low)
//                in_valid/in_ready, inputA, inputB, command  - request side
//                out_valid/out_ready, result, error          - response side
//                busy                                        - EXEC/ITER/FINAL
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     inputA,
    input  logic [WIDTH-1:0]     inputB,
    input  logic [3:0]           command,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 error,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_ITER  = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] c_cmd_add  = 4'd1;
    localparam logic [3:0] c_cmd_sub  = 4'd2;
    localparam logic [3:0] c_cmd_mult = 4'd3;
    localparam logic [3:0] c_cmd_div  = 4'd4;
    localparam logic [3:0] c_cmd_mod  = 4'd5;

    // Counter runs 0..WIDTH-1; the last value triggers the move to FINAL.
    localparam logic [4:0] c_last_step = 5'(WIDTH - 1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;        // operand A; dividend/quotient shifter for div/mod
    logic [WIDTH-1:0]       r_b;        // operand B; multiplier shifter for mult
    logic [3:0]             r_cmd;
    logic [4:0]             r_cnt;
    logic [2*WIDTH-1:0]     r_acc;      // product accumulator
    logic [WIDTH-1:0]       r_rem;      // partial remainder
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;
    logic [2*WIDTH-1:0]     r_result;
    logic                   r_error;

    // ------------------------------------------------------------------
    // Accept-time decode (from live inputs, used only on the accept edge)
    // ------------------------------------------------------------------
    logic w_in_is_divmod;
    logic w_in_iterates;

    assign w_in_is_divmod = (command == c_cmd_div) || (command == c_cmd_mod);
    assign w_in_iterates  = (command == c_cmd_mult) ||
                            (w_in_is_divmod && (inputB != '0));

    // ------------------------------------------------------------------
    // Add/sub: a single adder, subtraction as A + ~B + 1. command[1] is
    // 0 for add and 1 for sub, so it doubles as invert-select and carry-in.
    // Overflow is the carry into the MSB XOR the carry out of the MSB.
    // ------------------------------------------------------------------
    logic                   w_sub;
    logic [WIDTH-1:0]       w_b_opnd;
    logic [WIDTH:0]         w_sum_full;
    logic [WIDTH-1:0]       w_sum_low;
    logic                   w_overflow;
    logic                   w_is_addsub;

    assign w_sub       = r_cmd[1];
    assign w_b_opnd    = w_sub ? ~r_b : r_b;
    assign w_sum_full  = {1'b0, r_a} + {1'b0, w_b_opnd} + {{WIDTH{1'b0}}, w_sub};
    assign w_sum_low   = {1'b0, r_a[WIDTH-2:0]} + {1'b0, w_b_opnd[WIDTH-2:0]}
                         + {{(WIDTH-1){1'b0}}, w_sub};
    assign w_overflow  = w_sum_low[WIDTH-1] ^ w_sum_full[WIDTH];
    assign w_is_addsub = (r_cmd == c_cmd_add) || (r_cmd == c_cmd_sub);

    // ------------------------------------------------------------------
    // Multiply step: MSB-first, so the accumulator doubles each step and
    // A is added when the current multiplier MSB is set.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]     w_mul_next;

    assign w_mul_next = {r_acc[2*WIDTH-2:0], 1'b0}
                        + (r_b[WIDTH-1] ? {{WIDTH{1'b0}}, r_a} : {(2*WIDTH){1'b0}});

    // ------------------------------------------------------------------
    // Restoring divide step: shift the next dividend bit into the partial
    // remainder, trial-subtract B, keep the difference when non-negative.
    // The quotient bit is shifted into the vacated LSB of r_a, so after
    // WIDTH steps r_a holds the quotient.
    // ------------------------------------------------------------------
    logic [WIDTH:0]         w_rem_shift;
    logic [WIDTH:0]         w_rem_diff;
    logic                   w_rem_ge;

    assign w_rem_shift = {r_rem, r_a[WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_b};
    assign w_rem_ge    = ~w_rem_diff[WIDTH];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cmd       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= inputA;
                        r_b        <= inputB;
                        r_cmd      <= command;
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_rem      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= w_in_iterates ? S_ITER : S_EXEC;
                    end
                end

                S_EXEC: begin
                    // Add/sub produce a sign-extended sum; everything else
                    // that lands here (reserved, divide by zero) is an error.
                    if (w_is_addsub) begin
                        r_result <= {{WIDTH{w_sum_full[WIDTH-1]}}, w_sum_full[WIDTH-1:0]};
                        r_error  <= w_overflow;
                    end else begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                    end
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_ITER: begin
                    if (r_cmd == c_cmd_mult) begin
                        r_acc <= w_mul_next;
                        r_b   <= {r_b[WIDTH-2:0], 1'b0};
                    end else begin
                        r_rem <= w_rem_ge ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
                        r_a   <= {r_a[WIDTH-2:0], w_rem_ge};
                    end
                    if (r_cnt == c_last_step) begin
                        r_cnt   <= '0;
                        r_state <= S_FINAL;
                    end else begin
                        r_cnt   <= r_cnt + 5'd1;
                    end
                end

                S_FINAL: begin
                    case (r_cmd)
                        c_cmd_mult: r_result <= r_acc;
                        c_cmd_div:  r_result <= {{WIDTH{1'b0}}, r_a};
                        default:    r_result <= {{WIDTH{1'b0}}, r_rem};
                    endcase
                    r_error     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer. Inputs are
//                driven 1 time unit after the rising edge and outputs are
//                sampled at the same point.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] inputA;
    logic [15:0] inputB;
    logic [3:0]  command;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        error;
    logic        busy;

    int checks;
    int errors;

    alu_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inputA    (inputA),
        .inputB    (inputB),
        .command   (command),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .error     (error),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait for out_valid. lat = number of edges after
    // the accept edge at which out_valid was first seen (0 = timed out).
    // Operands are scrambled right after the accept edge. Returns #1 after
    // the edge that raised out_valid; the result is not consumed.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] cmd, output int lat,
                         output logic [31:0] res, output logic err);
        lat      = 0;
        inputA   = a;
        inputB   = b;
        command  = cmd;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inputA   = 16'($urandom);
        inputB   = 16'($urandom);
        command  = 4'($urandom);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        res = result;
        err = error;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        inputA    = 16'd3;
        inputB    = 16'd4;
        command   = 4'd1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (result !== 32'h0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: result=%h error=%b required 00000000 0", result, error);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_addsub();
        int          lat;
        logic [31:0] res;
        logic        err;
        logic [15:0] va [4] = '{16'd255,  16'd255,  16'h8000,     16'h7FFF};
        logic [15:0] vb [4] = '{16'd127,  16'd127,  16'd1,        16'd1};
        logic [3:0]  vc [4] = '{4'd1,     4'd2,     4'd2,         4'd1};
        logic [31:0] vr [4] = '{32'd382,  32'd128,  32'h00007FFF, 32'hFFFF8000};
        logic        ve [4] = '{1'b0,     1'b0,     1'b1,         1'b1};
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], vc[k], lat, res, err);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL addsub_latency[%0d]: got %0d required 1", k, lat);
            end
            checks++;
            if (res !== vr[k] || err !== ve[k]) begin
                errors++;
                $display("FAIL addsub_result[%0d]: got %h/%b required %h/%b",
                         k, res, err, vr[k], ve[k]);
            end
            consume();
        end
    endtask

    task automatic test_mult();
        int          lat;
        logic [31:0] res;
        logic        err;
        logic [15:0] va [2] = '{16'd255,   16'hFFFF};
        logic [15:0] vb [2] = '{16'd127,   16'hFFFF};
        logic [31:0] vr [2] = '{32'd32385, 32'hFFFE0001};
        for (int k = 0; k < 2; k++) begin
            do_op(va[k], vb[k], 4'd3, lat, res, err);
            checks++;
            if (lat !== 17) begin
                errors++;
                $display("FAIL mult_latency[%0d]: got %0d required 17", k, lat);
            end
            checks++;
            if (res !== vr[k] || err !== 1'b0) begin
                errors++;
                $display("FAIL mult_result[%0d]: got %h/%b required %h/0", k, res, err, vr[k]);
            end
            consume();
        end
    endtask

    task automatic test_divmod();
        int          lat;
        logic [31:0] res;
        logic        err;
        logic [15:0] va [3] = '{16'd1000, 16'd1000, 16'hFFFF};
        logic [15:0] vb [3] = '{16'd7,    16'd7,    16'd16};
        logic [3:0]  vc [3] = '{4'd4,     4'd5,     4'd5};
        logic [31:0] vr [3] = '{32'd142,  32'd6,    32'd15};
        for (int k = 0; k < 3; k++) begin
            do_op(va[k], vb[k], vc[k], lat, res, err);
            checks++;
            if (lat !== 17) begin
                errors++;
                $display("FAIL divmod_latency[%0d]: got %0d required 17", k, lat);
            end
            checks++;
            if (res !== vr[k] || err !== 1'b0) begin
                errors++;
                $display("FAIL divmod_result[%0d]: got %h/%b required %h/0", k, res, err, vr[k]);
            end
            consume();
        end
    endtask

    task automatic test_exceptions();
        int          lat;
        logic [31:0] res;
        logic        err;
        logic [15:0] va [4] = '{16'd5, 16'd5, 16'd9, 16'd9};
        logic [3:0]  vc [4] = '{4'd4,  4'd5,  4'd9,  4'd0};
        logic [15:0] vb [4] = '{16'd0, 16'd0, 16'd3, 16'd3};
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], vc[k], lat, res, err);
            checks++;
            if (lat !== 1 || res !== 32'h0 || err !== 1'b1) begin
                errors++;
                $display("FAIL exception[%0d]: lat=%0d result=%h error=%b required 1/00000000/1",
                         k, lat, res, err);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          bad;
        logic [31:0] res;
        logic        err;
        do_op(16'd10, 16'd20, 4'd1, lat, res, err);
        checks++;
        if (lat !== 1 || res !== 32'd30) begin
            errors++;
            $display("FAIL bp_first: lat=%0d result=%h required 1/0000001e", lat, res);
        end
        // Stall with a competing request pending.
        inputA   = 16'd50;
        inputB   = 16'd8;
        command  = 4'd2;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
                result !== 32'd30 || error !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles required 0 (result=%h in_ready=%b)",
                     bad, result, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: in_ready=%b busy=%b required 0 1", in_ready, busy);
        end
        lat = 0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 1 || result !== 32'd42 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d result=%h error=%b required 1/0000002a/0",
                     lat, result, error);
        end
        consume();
    endtask

    task automatic test_reset_mid_mult();
        int          lat;
        logic [31:0] res;
        logic        err;
        // Leave a nonzero result in place so the reset clear is visible.
        do_op(16'd100, 16'd3, 4'd3, lat, res, err);
        consume();
        inputA   = 16'd255;
        inputB   = 16'd127;
        command  = 4'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_mult_busy: busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            result !== 32'h0 || error !== 1'b0) begin
            errors++;
            $display("FAIL mid_mult_reset: rdy=%b vld=%b busy=%b result=%h err=%b required 1 0 0 0 0",
                     in_ready, out_valid, busy, result, error);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(16'd2, 16'd3, 4'd1, lat, res, err);
        checks++;
        if (lat !== 1 || res !== 32'd5 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_add: lat=%0d result=%h error=%b required 1/00000005/0",
                     lat, res, err);
        end
        consume();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inputA    = '0;
        inputB    = '0;
        command   = '0;
        rst_n     = 1'b0;
        #2;
        test_reset();
        test_addsub();
        test_mult();
        test_divmod();
        test_exceptions();
        test_back_to_back();
        test_reset_mid_mult();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle command sequencer for the 16-bit arithmetic datapath. It accepts one operation at a time (add, sub, mult, div, mod) over a valid/ready request handshake. Add/sub complete in one execute cycle; mult and div/mod run as 16-step shift-add and restoring-divide loops. The result is held on a valid/ready response handshake until it is consumed. The block sits between the command source (decoder/test driver) and the result consumer, and replaces the combinational breadboard path.

## Interface
Parameters:
- WIDTH, 16, operand width; result is 2*WIDTH; iteration count = WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request ready; high only in IDLE
- inputA  in  WIDTH  operand A
- inputB  in  WIDTH  operand B
- command  in  4  1=add, 2=sub, 3=mult, 4=div, 5=mod; 0 and 6..15 reserved
- out_valid  out  1  result valid; held until consumed
- out_ready  in  1  consumer ready
- result  out  2*WIDTH  registered result
- error  out  1  registered error flag, paired with result
- busy  out  1  high in EXEC, ITER, FINAL

## Operation
- States: IDLE, EXEC, ITER, FINAL, DONE.
- Accept: in_valid & in_ready at a rising edge. Operands and command are latched.
- Next state on accept:
  - add/sub/reserved and div/mod with B=0 → EXEC
  - mult, or div/mod with B≠0 → ITER, with the 5-bit counter cleared
- EXEC (1 cycle) → DONE.
- ITER runs 16 cycles (counter 0..15) → FINAL (1 cycle) → DONE.
- DONE holds until out_valid & out_ready at an edge → IDLE.
- Add/sub:
  - Two's-complement 16-bit. Sub = A + ~B + 1, i.e. the adder with carry-in = command[1].
  - result = sum sign-extended to 32 bits.
  - error = signed overflow (carry into MSB XOR carry out).
- Mult: unsigned 16x16 → 32. MSB-first shift-add, one bit per ITER cycle. error = 0.
- Div/mod: unsigned restoring division, one quotient bit per ITER cycle.
  - div: result = {16'b0, quotient}
  - mod: result = {16'b0, remainder}
  - error = 0
- B=0 with div/mod: result = 0, error = 1, via EXEC. No iteration.
- Reserved command: result = 0, error = 1, via EXEC.
- result and error change only on the transition into DONE. They stay stable while out_valid=1.
- No bypass: in_ready stays low from the accept edge until the edge after the result is consumed.

## Timing
- Reset (async, immediate on rst_n low):
  - state = IDLE, in_ready = 1, out_valid = 0, result = 0, error = 0, busy = 0, counter = 0.
  - No request is accepted while rst_n is low.
- Accept at edge N; all outputs registered.
- Add/sub/reserved/div-by-zero: out_valid = 1 after edge N+1.
- Mult/div/mod: ITER on edges N+1..N+16, FINAL at edge N+17; out_valid = 1 after edge N+17.
- out_ready sampled at edge M with out_valid = 1 → out_valid = 0 and in_ready = 1 after M. Earliest next accept is edge M+1.
- out_ready high before out_valid has no effect.
- Changes on inputA/inputB/command after accept have no effect on the operation in flight.
- Reset mid-operation aborts it. No result is emitted; the block restarts in IDLE.
- Counter wrap: the transition to FINAL happens at counter = 15. The counter never exceeds 15.

## Test plan
- Add: A=255, B=127, cmd=1 accepted at edge N → out_valid after N+1, result=382, error=0.
- Sub overflow:
  - A=255, B=127, cmd=2 → result=128, error=0.
  - A=0x8000, B=1, cmd=2 → result=0x00007FFF, error=1.
  - A=0x7FFF, B=1, cmd=1 → result=0xFFFF8000, error=1.
- Mult: A=255, B=127, cmd=3 → out_valid after exactly N+17, result=32385. Also A=B=0xFFFF → result=0xFFFE0001, error=0.
- Div/mod and exceptions:
  - A=1000, B=7: cmd=4 → 142; cmd=5 → 6.
  - A=5, B=0, cmd=4 → result=0, error=1, after N+1.
  - cmd=9 → result=0, error=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - result/error stay stable, in_ready stays 0, new in_valid is ignored.
  - Raise out_ready → in_ready=1 next cycle; a back-to-back request is accepted at the following edge.
- Reset mid-mult: assert rst_n=0 at ITER counter=7 → outputs immediately at reset values. After release, a fresh add 2+3 gives result=5.
